// File: rtl/stateful_rmw.sv
// Stateful read-modify-write atom: an indexed bank of state words, each read,
// updated by an opcode-selected function and written back, one op per clock.
module stateful_rmw #(
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [IDX_WIDTH-1:0]   i_idx,
  input  logic [COUNT_WIDTH-1:0] pkt_1,
  input  logic [COUNT_WIDTH-1:0] cons_1,
  input  logic [2:0]             opcode,
  output logic                   o_valid,
  output logic [IDX_WIDTH-1:0]   o_idx,
  output logic [COUNT_WIDTH-1:0] o_read,
  output logic [COUNT_WIDTH-1:0] o_write
);

  localparam int DEPTH = 2 ** IDX_WIDTH;

  typedef enum logic [2:0] {
    OP_READ = 3'd0,
    OP_ADDP = 3'd1,
    OP_ADDC = 3'd2,
    OP_SETP = 3'd3,
    OP_MAXP = 3'd4,
    OP_SINC = 3'd5,
    OP_CLR  = 3'd6,
    OP_CAS  = 3'd7
  } op_t;

  // The bank must clear on reset, so it lives in flops rather than block RAM.
  logic [COUNT_WIDTH-1:0] bank [DEPTH];

  logic                   s1_valid;
  logic [IDX_WIDTH-1:0]   s1_idx;
  op_t                    s1_op;
  logic [COUNT_WIDTH-1:0] s1_pkt;
  logic [COUNT_WIDTH-1:0] s1_cons;
  logic [COUNT_WIDTH-1:0] s1_old;

  logic [COUNT_WIDTH-1:0] new_val;
  logic                   s1_wr;
  logic                   bypass;
  logic [COUNT_WIDTH-1:0] s0_old;

  always_comb begin
    new_val = s1_old;
    case (s1_op)
      OP_READ: new_val = s1_old;
      OP_ADDP: new_val = s1_old + s1_pkt;
      OP_ADDC: new_val = s1_old + s1_cons;
      OP_SETP: new_val = s1_pkt;
      OP_MAXP: new_val = (s1_old > s1_pkt) ? s1_old : s1_pkt;
      OP_SINC: new_val = (s1_old >= s1_cons) ? s1_old : s1_old + 1'b1;
      OP_CLR:  new_val = '0;
      OP_CAS:  new_val = (s1_old == s1_cons) ? s1_pkt : s1_old;
      default: new_val = s1_old;
    endcase
  end

  assign s1_wr = s1_valid && (s1_op != OP_READ);

  // Forward the in-flight result so back-to-back ops on one entry chain exactly.
  assign bypass = s1_wr && (s1_idx == i_idx);
  assign s0_old = bypass ? new_val : bank[i_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_op    <= OP_READ;
      s1_pkt   <= '0;
      s1_cons  <= '0;
      s1_old   <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_idx  <= i_idx;
        s1_op   <= op_t'(opcode);
        s1_pkt  <= pkt_1;
        s1_cons <= cons_1;
        s1_old  <= s0_old;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        bank[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (s1_wr && (s1_idx == IDX_WIDTH'(k))) begin
          bank[k] <= new_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_read  <= '0;
      o_write <= '0;
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_idx   <= s1_idx;
        o_read  <= s1_old;
        o_write <= new_val;
      end
    end
  end

endmodule

// File: tb/tb_stateful_rmw.sv
// Bench for stateful_rmw: directed and random ops against a sequential
// model of the state bank, one report line per checked result.
module tb_stateful_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [3:0]  i_idx;
  logic [31:0] pkt_1;
  logic [31:0] cons_1;
  logic [2:0]  opcode;
  logic        o_valid;
  logic [3:0]  o_idx;
  logic [31:0] o_read;
  logic [31:0] o_write;

  stateful_rmw #(.COUNT_WIDTH(32), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_idx(i_idx),
    .pkt_1(pkt_1), .cons_1(cons_1), .opcode(opcode),
    .o_valid(o_valid), .o_idx(o_idx), .o_read(o_read), .o_write(o_write)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] bank_m [16];
  bit          exp_valid;
  logic [3:0]  hold_idx;
  logic [31:0] hold_read, hold_write;
  bit          nxt_valid;
  logic [3:0]  nxt_idx;
  logic [31:0] nxt_read, nxt_write;

  function automatic logic [31:0] apply(input int op, input logic [31:0] old,
                                        input logic [31:0] pkt, input logic [31:0] cons);
    case (op)
      1: return old + pkt;
      2: return old + cons;
      3: return pkt;
      4: return (old > pkt) ? old : pkt;
      5: return (old >= cons) ? old : old + 32'd1;
      6: return 32'd0;
      7: return (old == cons) ? pkt : old;
      default: return old;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    if (exp_valid) begin
      hold_idx   = nxt_idx;
      hold_read  = nxt_read;
      hold_write = nxt_write;
    end
    chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    chk("o_idx",   {28'd0, o_idx},   {28'd0, hold_idx});
    chk("o_read",  o_read,  hold_read);
    chk("o_write", o_write, hold_write);
    $display("t=%0t v=%0b idx=%0d read=%h write=%h", $time, o_valid, o_idx, o_read, o_write);
  endtask

  // Drive one cycle's input; the result of the op accepted one edge earlier is checked.
  task automatic step(input bit v, input int idx, input int op,
                      input logic [31:0] pkt, input logic [31:0] cons);
    bit          pv;
    logic [3:0]  pi;
    logic [31:0] pr, pw, old;
    i_valid = v;
    i_idx   = idx[3:0];
    opcode  = op[2:0];
    pkt_1   = pkt;
    cons_1  = cons;
    pv = v; pi = idx[3:0]; pr = '0; pw = '0;
    if (v) begin
      old = bank_m[idx];
      pr  = old;
      pw  = apply(op, old, pkt, cons);
      if (op != 0) bank_m[idx] = pw;
    end
    @(posedge clk);
    #1;
    check_outputs();
    exp_valid = pv; nxt_idx = pi; nxt_read = pr; nxt_write = pw;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) bank_m[k] = '0;
    exp_valid = 1'b0;
    hold_idx = '0; hold_read = '0; hold_write = '0;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_idx = '0; pkt_1 = '0; cons_1 = '0; opcode = '0;
    exp_valid = 1'b0; nxt_idx = '0; nxt_read = '0; nxt_write = '0;
    hold_idx = '0; hold_read = '0; hold_write = '0;
    for (int k = 0; k < 16; k++) bank_m[k] = '0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    do_reset();

    step(1, 3, 0, 32'd77, 32'd88);
    step(0, 0, 0, 0, 0);
    chk("read_only_write", o_write, 32'd0);

    for (int n = 0; n < 4; n++) step(1, 2, 1, 32'd5, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("chain_end_read", o_read, 32'd15);
    chk("chain_end_write", o_write, 32'd20);

    step(1, 1, 3, 32'hFFFF_FFFF, 32'd0);
    step(1, 1, 2, 32'd0, 32'd2);
    step(0, 0, 0, 0, 0);
    chk("wrap_read", o_read, 32'hFFFF_FFFF);
    chk("wrap_write", o_write, 32'd1);

    for (int n = 0; n < 4; n++) step(1, 0, 5, 32'd0, 32'd2);
    step(0, 0, 0, 0, 0);
    chk("sat_write", o_write, 32'd2);

    step(1, 4, 7, 32'd9, 32'd0);
    step(1, 4, 7, 32'd7, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("cas_fail_write", o_write, 32'd9);

    step(1, 5, 3, 32'd11, 0);
    step(0, 0, 0, 0, 0);
    step(1, 6, 3, 32'd22, 0);
    step(0, 0, 0, 0, 0);
    step(1, 5, 3, 32'd33, 0);
    do_reset();
    chk("rst_o_write", o_write, 32'd0);
    step(1, 5, 0, 0, 0);
    step(1, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_read6", o_read, 32'd0);

    for (int n = 0; n < 400; n++) begin
      int idx, op;
      logic [31:0] pkt, cons;
      idx  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
      op   = int'($urandom_range(0, 7));
      pkt  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 50));
      cons = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (op == 7 && $urandom_range(0, 1) == 0) cons = bank_m[idx];
      if (n == 200) do_reset();
      step($urandom_range(0, 4) != 0, idx, op, pkt, cons);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
